// File: rtl/fifo_frame_writer.sv
// Frames a payload as preamble, sync, length, payload and XOR checksum
// into a write-side FIFO, one byte per wclk edge with winc high.
//
// Ports:
//   wclk, resetn          clock, async active-low reset
//   start, len            frame request and payload length (IDLE only)
//   abort                 synchronous frame abandon
//   s_valid, s_data       upstream payload byte
//   s_ready               payload byte taken on this edge
//   wfull                 FIFO full flag
//   winc, wdata           FIFO write strobe and data
//   busy, done, frames    status, completion pulse, frame counter
module fifo_frame_writer #(
   parameter logic [7:0] PREAMBLE = 8'h55,
   parameter int         PRE_LEN  = 2,
   parameter logic [7:0] SYNC     = 8'hD5
) (
   input  logic        wclk,
   input  logic        resetn,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic        abort,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   input  logic        wfull,
   output logic        winc,
   output logic [7:0]  wdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] frames
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SYNC,
      S_LEN,
      S_PAY,
      S_CHK,
      S_DONE
   } state_t;

   localparam logic [3:0] PRE_LAST = 4'(PRE_LEN - 1);

   state_t      state_q, state_d;
   logic [3:0]  pre_q, pre_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  chk_q, chk_d;
   logic [15:0] frames_q;
   logic        wr_ok;

   assign wr_ok = ~wfull;

   always_ff @(posedge wclk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         chk_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         chk_q   <= chk_d;
      end
   end

   // Counter only written on the DONE edge so it holds otherwise.
   always_ff @(posedge wclk or negedge resetn) begin
      if (!resetn)
         frames_q <= '0;
      else if (state_q == S_DONE && !abort)
         frames_q <= frames_q + 16'd1;
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      len_d   = len_q;
      rem_d   = rem_q;
      chk_d   = chk_q;
      winc    = 1'b0;
      wdata   = 8'h00;
      s_ready = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PRE;
               pre_d   = '0;
               len_d   = len;
               rem_d   = len;
               // Checksum seeds with the length byte.
               chk_d   = len;
            end
         end
         S_PRE: begin
            winc  = wr_ok;
            wdata = PREAMBLE;
            if (wr_ok) begin
               if (pre_q == PRE_LAST) begin
                  state_d = S_SYNC;
                  pre_d   = '0;
               end else begin
                  pre_d = pre_q + 4'd1;
               end
            end
         end
         S_SYNC: begin
            winc  = wr_ok;
            wdata = SYNC;
            if (wr_ok)
               state_d = S_LEN;
         end
         S_LEN: begin
            winc  = wr_ok;
            wdata = len_q;
            if (wr_ok)
               state_d = (len_q == 8'd0) ? S_CHK : S_PAY;
         end
         S_PAY: begin
            s_ready = wr_ok;
            winc    = s_valid & wr_ok;
            wdata   = s_data;
            if (s_valid && wr_ok) begin
               chk_d = chk_q ^ s_data;
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1)
                  state_d = S_CHK;
            end
         end
         S_CHK: begin
            winc  = wr_ok;
            wdata = chk_q;
            if (wr_ok)
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            chk_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over any same-edge transfer; the write itself
      // still lands in the FIFO since winc is left untouched.
      if (abort) begin
         state_d = S_IDLE;
         pre_d   = '0;
         len_d   = '0;
         rem_d   = '0;
         chk_d   = '0;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign frames = frames_q;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Self-checking bench for fifo_frame_writer.
// Scoreboard of expected FIFO bytes, checked on every winc.
module tb_fifo_frame_writer;

   localparam int PL = 2;

   logic        wclk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = 8'h00;
   logic        abort = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_ready;
   logic        wfull = 1'b0;
   logic        winc;
   logic [7:0]  wdata;
   logic        busy;
   logic        done;
   logic [15:0] frames;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] pay_q[$];
   logic [7:0] mon_e;
   int done_cnt = 0;
   int wr_cnt = 0;
   int take_cnt = 0;
   logic take_n = 1'b0;
   bit tog = 1'b0;
   bit tog_mode = 1'b0;
   bit src_en = 1'b0;
   logic [15:0] exp_frames = 16'h0000;

   always #5 wclk = ~wclk;

   fifo_frame_writer #(
      .PREAMBLE(8'h55),
      .PRE_LEN (PL),
      .SYNC    (8'hD5)
   ) dut (
      .wclk   (wclk),
      .resetn (resetn),
      .start  (start),
      .len    (len),
      .abort  (abort),
      .s_valid(s_valid),
      .s_data (s_data),
      .s_ready(s_ready),
      .wfull  (wfull),
      .winc   (winc),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .frames (frames)
   );

   // Output monitor: every write must match the scoreboard head.
   always @(negedge wclk) begin
      take_n = s_valid && s_ready;
      if (take_n) take_cnt++;
      if (done) done_cnt++;
      if (winc) begin
         wr_cnt++;
         checks++;
         if (wfull) begin
            errors++;
            $display("FAIL winc_while_full: winc=1 wfull=1 required winc=0");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: wdata=%h required no write", wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (wdata !== mon_e) begin
               errors++;
               $display("FAIL wdata: got %h required %h", wdata, mon_e);
            end
         end
      end
   end

   // Payload source: consumes a byte after each accepted edge.
   always @(posedge wclk) begin
      #1;
      if (take_n && pay_q.size() > 0) void'(pay_q.pop_front());
      tog = ~tog;
      s_valid = src_en && (pay_q.size() > 0) && (!tog_mode || tog);
      s_data = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
   end

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic load_frame(input logic [7:0] n, input logic [7:0] p[$]);
      logic [7:0] c;
      c = n;
      foreach (p[i]) c = c ^ p[i];
      for (int i = 0; i < PL; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      exp_q.push_back(n);
      foreach (p[i]) begin
         exp_q.push_back(p[i]);
         pay_q.push_back(p[i]);
      end
      exp_q.push_back(c);
      src_en = 1'b1;
   endtask

   // Starts a frame and waits, bounded, until done is seen at a negedge.
   task automatic send_frame(input logic [7:0] n, input logic [7:0] p[$],
                             output int lat, output bit to);
      load_frame(n, p);
      start = 1'b1;
      len = n;
      tick();
      start = 1'b0;
      lat = 1;
      to = 1'b0;
      while (1) begin
         @(negedge wclk);
         if (done) break;
         if (lat > 300) begin
            to = 1'b1;
            break;
         end
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      @(negedge wclk);
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rst_winc: got %b required 0", winc); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
      checks++; if (frames !== 16'h0000) begin errors++; $display("FAIL rst_frames: got %h required 0000", frames); end
      checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h required 00", wdata); end
      tick();
      resetn = 1'b1;
      repeat (3) tick();
      @(negedge wclk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b required 0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] p[$];
      int lat;
      bit to;
      int d0;
      p = '{8'h01, 8'h02, 8'h04};
      d0 = done_cnt;
      send_frame(8'd3, p, lat, to);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout: done not seen required done"); end
      checks++; if (lat != PL + 3 + 4) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, PL + 7); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_done: got %b required 0", s_ready); end
      tick();
      exp_frames = exp_frames + 16'd1;
      @(negedge wclk);
      checks++; if (frames !== exp_frames) begin errors++; $display("FAIL basic_frames: got %h required %h", frames, exp_frames); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: done=%b busy=%b required 0 0", done, busy); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulse: got %0d required 1", done_cnt - d0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_len0();
      logic [7:0] p[$];
      int lat;
      bit to;
      p = {};
      send_frame(8'd0, p, lat, to);
      checks++; if (to) begin errors++; $display("FAIL len0_timeout: done not seen required done"); end
      checks++; if (lat != PL + 4) begin errors++; $display("FAIL len0_latency: got %0d required %0d", lat, PL + 4); end
      tick();
      exp_frames = exp_frames + 16'd1;
      @(negedge wclk);
      checks++; if (frames !== exp_frames) begin errors++; $display("FAIL len0_frames: got %h required %h", frames, exp_frames); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL len0_left: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_wfull_sync();
      logic [7:0] p[$];
      int w0;
      int n;
      p = '{8'hA5};
      w0 = wr_cnt;
      load_frame(8'd1, p);
      start = 1'b1;
      len = 8'd1;
      tick();
      start = 1'b0;
      tick();
      tick();
      wfull = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge wclk);
         checks++; if (winc !== 1'b0) begin errors++; $display("FAIL full_winc: cyc %0d got %b required 0", i, winc); end
         checks++; if (wdata !== 8'hD5) begin errors++; $display("FAIL full_wdata: cyc %0d got %h required d5", i, wdata); end
         tick();
      end
      wfull = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      checks++; if (!done) begin errors++; $display("FAIL full_timeout: done=%b required 1", done); end
      tick();
      exp_frames = exp_frames + 16'd1;
      @(negedge wclk);
      checks++; if (wr_cnt - w0 != PL + 4) begin errors++; $display("FAIL full_writes: got %0d required %0d", wr_cnt - w0, PL + 4); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_left: got %0d required 0", exp_q.size()); end
      checks++; if (frames !== exp_frames) begin errors++; $display("FAIL full_frames: got %h required %h", frames, exp_frames); end
   endtask

   task automatic test_toggle();
      logic [7:0] p[$];
      int lat;
      bit to;
      int t0;
      p = '{8'h11, 8'h22, 8'h44, 8'h88};
      t0 = take_cnt;
      tog_mode = 1'b1;
      send_frame(8'd4, p, lat, to);
      checks++; if (to) begin errors++; $display("FAIL tog_timeout: done not seen required done"); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL tog_s_ready_done: got %b required 0", s_ready); end
      tick();
      tog_mode = 1'b0;
      exp_frames = exp_frames + 16'd1;
      @(negedge wclk);
      checks++; if (take_cnt - t0 != 4) begin errors++; $display("FAIL tog_takes: got %0d required 4", take_cnt - t0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tog_left: got %0d required 0", exp_q.size()); end
      checks++; if (frames !== exp_frames) begin errors++; $display("FAIL tog_frames: got %h required %h", frames, exp_frames); end
   endtask

   task automatic test_abort();
      logic [7:0] p[$];
      int lat;
      bit to;
      int d0;
      p = {};
      for (int i = 0; i < 10; i++) p.push_back(8'(i * 3 + 7));
      load_frame(8'd10, p);
      start = 1'b1;
      len = 8'd10;
      tick();
      start = 1'b0;
      repeat (7) tick();
      d0 = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge wclk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL abort_winc: got %b required 0", winc); end
      exp_q.delete();
      pay_q.delete();
      src_en = 1'b0;
      repeat (5) tick();
      @(negedge wclk);
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done: got %0d pulses required 0", done_cnt - d0); end
      checks++; if (frames !== exp_frames) begin errors++; $display("FAIL abort_frames: got %h required %h", frames, exp_frames); end
      tick();
      start = 1'b1;
      abort = 1'b1;
      len = 8'd3;
      tick();
      start = 1'b0;
      abort = 1'b0;
      @(negedge wclk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy: got %b required 0", busy); end
      tick();
      p = '{8'h9A, 8'hBC};
      send_frame(8'd2, p, lat, to);
      checks++; if (to) begin errors++; $display("FAIL abort_next_timeout: done not seen required done"); end
      checks++; if (lat != PL + 2 + 4) begin errors++; $display("FAIL abort_next_latency: got %0d required %0d", lat, PL + 6); end
      tick();
      exp_frames = exp_frames + 16'd1;
      @(negedge wclk);
      checks++; if (frames !== exp_frames) begin errors++; $display("FAIL abort_next_frames: got %h required %h", frames, exp_frames); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_next_left: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] p[$];
      int w0;
      p = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      load_frame(8'd5, p);
      start = 1'b1;
      len = 8'd5;
      tick();
      start = 1'b0;
      repeat (6) tick();
      resetn = 1'b0;
      @(negedge wclk);
      w0 = wr_cnt;
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rmid_winc: got %b required 0", winc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
      checks++; if (frames !== 16'h0000) begin errors++; $display("FAIL rmid_frames: got %h required 0000", frames); end
      exp_q.delete();
      pay_q.delete();
      src_en = 1'b0;
      exp_frames = 16'h0000;
      repeat (3) tick();
      resetn = 1'b1;
      repeat (3) tick();
      @(negedge wclk);
      checks++; if (wr_cnt != w0) begin errors++; $display("FAIL rmid_writes: got %0d required 0", wr_cnt - w0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_restart: busy=%b required 0", busy); end
   endtask

   task automatic test_wrap();
      logic [7:0] p[$];
      int lat;
      bit to;
      p = {};
      tick();
      force dut.frames_q = 16'hFFFF;
      tick();
      release dut.frames_q;
      tick();
      @(negedge wclk);
      checks++; if (frames !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h required ffff", frames); end
      tick();
      send_frame(8'd0, p, lat, to);
      checks++; if (to) begin errors++; $display("FAIL wrap_timeout: done not seen required done"); end
      tick();
      @(negedge wclk);
      checks++; if (frames !== 16'h0000) begin errors++; $display("FAIL wrap_frames: got %h required 0000", frames); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_len0();
      test_wfull_sync();
      test_toggle();
      test_abort();
      test_reset_mid();
      test_wrap();
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_frame_writer.md
FIFO_FRAME_WRITER -- requirements
Module: fifo_frame_writer

Interface
REQ-001 The block SHALL have parameter PREAMBLE, default 8'h55, preamble byte value.
REQ-002 The block SHALL have parameter PRE_LEN, default 2, number of preamble bytes (1..15).
REQ-003 The block SHALL have parameter SYNC, default 8'hD5, start-of-frame delimiter.
REQ-004 Reset SHALL be resetn, asynchronous, active-low; clock SHALL be wclk.
REQ-005 Ports SHALL be, in order (name  direction  width  meaning):
 wclk  in  1  write-domain clock
 resetn  in  1  async active-low reset
 start  in  1  request a frame, sampled in IDLE only
 len  in  8  payload byte count, sampled with start
 abort  in  1  synchronous frame abandon
 s_valid  in  1  upstream payload byte valid
 s_data  in  8  upstream payload byte
 s_ready  out  1  payload byte accepted this edge when s_valid=1
 wfull  in  1  FIFO full flag (wclk domain)
 winc  out  1  FIFO write strobe
 wdata  out  8  FIFO write data
 busy  out  1  frame in progress
 done  out  1  one-cycle pulse, frame complete
 frames  out  16  completed-frame counter

Function
REQ-006 Frame byte order SHALL be: PRE_LEN x PREAMBLE, SYNC, LEN, LEN payload bytes, CHK.
REQ-007 CHK SHALL be the 8-bit XOR of LEN and all payload bytes; LEN=0 gives CHK=8'h00.
REQ-008 FSM states SHALL be IDLE, PRE, SYNC, LEN, PAY, CHK, DONE.
REQ-009 IDLE->PRE SHALL occur on a rising edge with start=1; len SHALL be latched; start in any other state SHALL be ignored.
REQ-010 A byte SHALL transfer to the FIFO on every rising edge where winc=1; winc SHALL be combinational: (state in PRE/SYNC/LEN/CHK & ~wfull) or (state=PAY & s_valid & ~wfull).
REQ-011 winc SHALL never be 1 while wfull=1; a state holding a pending byte SHALL keep wdata stable until the transfer occurs.
REQ-012 In PAY, s_ready SHALL be ~wfull and wdata SHALL equal s_data; s_ready SHALL be 0 in all other states.
REQ-013 PRE SHALL advance to SYNC after PRE_LEN transfers (internal 4-bit counter); SYNC->LEN and LEN->PAY (or ->CHK if LEN=0) SHALL each take one transfer.
REQ-014 PAY SHALL count down from LEN; the transfer of the last payload byte SHALL move to CHK.
REQ-015 CHK->DONE SHALL occur on the CHK transfer; DONE SHALL last exactly one cycle, assert done=1, increment frames (mod 2^16, 16'hFFFF wraps to 0), then return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE; with wfull=0 and s_valid=1 constantly, start to done SHALL be PRE_LEN+LEN+4 cycles.
REQ-017 abort=1 on a rising edge SHALL force IDLE from any state, clear checksum and counters, leave frames unchanged, and produce no done; abort takes priority over a same-edge transfer, which still completes in the FIFO.
REQ-018 abort and start on the same edge in IDLE SHALL leave the block in IDLE.

Reset
REQ-019 While resetn=0: state=IDLE, winc=0, s_ready=0, busy=0, done=0, frames=0, wdata=8'h00, checksum and counters=0.
REQ-020 Reset assertion mid-frame SHALL abandon the frame immediately with no further writes.
REQ-021 Release of resetn SHALL take effect at the next wclk edge; no frame starts without start.

Verification
REQ-022 start, len=3, payload 8'h01,8'h02,8'h04, wfull=0 -> wdata sequence 55,55,D5,03,01,02,04,04; done at cycle 9; frames=1.
REQ-023 start, len=0 -> 55,55,D5,00,00; done pulse; frames increments.
REQ-024 wfull=1 for 5 cycles during SYNC -> winc=0 and wdata=D5 held throughout; D5 written once after wfull falls.
REQ-025 s_valid toggling 1/0 during PAY with len=4 -> exactly 4 payload writes, correct CHK, s_ready only in PAY.
REQ-026 abort during PAY of len=10 -> IDLE next cycle, busy=0, no done, frames unchanged; a following start gives a full correct frame.
REQ-027 frames preloaded to 16'hFFFF via 65535 len=0 frames (or forced) -> next done wraps frames to 16'h0000.
